// File: rtl/serial_mux_scheduler_if.sv
// Bus bundle for serial_mux_scheduler: requester side (start/req/mux_in)
// and scheduler outputs (ack/grant_id/sel/out/frame/busy).
interface serial_mux_scheduler_if;
  logic        start;
  logic [3:0]  req;
  logic [31:0] mux_in;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic [2:0]  sel;
  logic        out;
  logic        frame;
  logic        busy;

  modport master (
    output start, req, mux_in,
    input  ack, grant_id, sel, out, frame, busy
  );

  modport slave (
    input  start, req, mux_in,
    output ack, grant_id, sel, out, frame, busy
  );
endinterface

// File: rtl/serial_mux_scheduler.sv
// Round-robin 4:1 word scheduler that serialises the winner's byte over 8 cycles.
// Define MSB_FIRST_EN to shift MSB first (sel 7..0); default is LSB first (sel 0..7).
module serial_mux_scheduler #(
  parameter int GAP = 1
) (
  input  logic                   clk,
  input  logic                   master_rst,
  serial_mux_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;

  localparam logic [2:0] GAP_LAST = (GAP == 0) ? 3'd0 : 3'(GAP - 1);
`ifdef MSB_FIRST_EN
  localparam logic [2:0] SEL_FIRST = 3'd7;
`else
  localparam logic [2:0] SEL_FIRST = 3'd0;
`endif

  state_t      state_q, state_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [2:0]  sel_q, sel_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  gap_cnt_q, gap_cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [3:0]  ack_q, ack_d;
  logic        out_q, out_d;
  logic        frame_q, frame_d;
  logic        busy_q, busy_d;
  logic [1:0]  cand;
  logic [1:0]  winner;
  logic        found;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (master_rst) begin
      state_q      <= S_IDLE;
      shadow_q     <= 8'h00;
      sel_q        <= 3'd0;
      bit_cnt_q    <= 3'd0;
      gap_cnt_q    <= 3'd0;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      ack_q        <= 4'b0000;
      out_q        <= 1'b0;
      frame_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      out_q        <= out_d;
      frame_q      <= frame_d;
      busy_q       <= busy_d;
    end
  end

  // Arbitration, next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    sel_d        = sel_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack_d        = 4'b0000;
    cand         = 2'd0;
    winner       = 2'd0;
    found        = 1'b0;

    // Search starts one past the last winner so every requester gets a turn
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && found) begin
          shadow_d     = bus.mux_in[8*winner +: 8];
          grant_d      = winner;
          last_grant_d = winner;
          ack_d        = 4'b0001 << winner;
          sel_d        = SEL_FIRST;
          bit_cnt_d    = 3'd0;
          state_d      = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == 3'd7) begin
          gap_cnt_d = 3'd0;
          if (GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef MSB_FIRST_EN
          sel_d = sel_q - 3'd1;
`else
          sel_d = sel_q + 3'd1;
`endif
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    frame_d = (state_d == S_SHIFT);
    busy_d  = (state_d != S_IDLE);
    out_d   = frame_d ? shadow_d[sel_d] : 1'b0;
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.sel      = sel_q;
  assign bus.out      = out_q;
  assign bus.frame    = frame_q;
  assign bus.busy     = busy_q;

endmodule
